// File: rtl/renode_pkg.sv
// Shared types and helpers for the Renode interrupt event path.
package renode_pkg;

  localparam int unsigned MaxIndexWidth = 16;

  // One interrupt event as delivered to the connection-side sender.
  typedef struct packed {
    logic [MaxIndexWidth-1:0] index;
    logic                     level;
  } irq_event_t;

  // Round-robin successor of idx among count lines.
  function automatic int unsigned next_rr_index(input int unsigned idx, input int unsigned count);
    return (idx + 32'd1 >= count) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/renode_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after ptr, wrapping.
module renode_rr_arbiter
  import renode_pkg::*;
#(
  parameter int unsigned ReqCount   = 1,
  parameter int unsigned IndexWidth = 1
) (
  input  logic [ReqCount-1:0]   req,
  input  logic [IndexWidth-1:0] ptr,
  input  logic                  en,
  output logic [IndexWidth-1:0] grant_c,
  output logic                  grant_valid_c
);

  // Scan requests starting at ptr; the first hit wins.
  always_comb begin
    int unsigned idx;
    grant_c       = '0;
    grant_valid_c = 1'b0;
    idx           = 32'd0;
    for (int unsigned k = 0; k < ReqCount; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= ReqCount) idx = idx - ReqCount;
      if (en && !grant_valid_c && |(req & (ReqCount'(1) << idx))) begin
        grant_c       = IndexWidth'(idx);
        grant_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/renode_interrupts_arbiter.sv
// Watches interrupt level lines and reports each change as an {index, level}
// event on a valid/ready port. Optional glitch counter under
// RENODE_INTERRUPTS_GLITCH_COUNT_EN.
module renode_interrupts_arbiter
  import renode_pkg::*;
#(
  parameter int unsigned InterruptsCount = 1,
  parameter int unsigned IndexWidth      = $clog2(InterruptsCount > 1 ? InterruptsCount : 2)
`ifdef RENODE_INTERRUPTS_GLITCH_COUNT_EN
  ,
  parameter int unsigned GlitchCntWidth  = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [InterruptsCount-1:0] interrupts,
  input  logic [InterruptsCount-1:0] irq_enable,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [IndexWidth-1:0]      evt_index,
  output logic                       evt_level,
  output logic [InterruptsCount-1:0] pending
`ifdef RENODE_INTERRUPTS_GLITCH_COUNT_EN
  ,
  output logic [GlitchCntWidth-1:0]  glitch_cnt
`endif
);

  localparam int unsigned N = InterruptsCount;

  logic [N-1:0]          reported;
  logic [N-1:0]          reported_d;
  logic [N-1:0]          grant_mask;
  logic [IndexWidth-1:0] rr_ptr;
  logic [IndexWidth-1:0] grant;
  logic                  grant_valid;
  logic                  slot_free;
  logic                  grant_take;
  logic                  grant_level;

  assign pending     = irq_enable & (interrupts ^ reported);
  assign slot_free   = !evt_valid || evt_ready;
  assign grant_take  = slot_free && grant_valid;
  assign grant_mask  = N'(1) << grant;
  assign grant_level = |(interrupts & grant_mask);

  renode_rr_arbiter #(
    .ReqCount   (N),
    .IndexWidth (IndexWidth)
  ) u_rr_arbiter (
    .req           (pending),
    .ptr           (rr_ptr),
    .en            (slot_free),
    .grant_c       (grant),
    .grant_valid_c (grant_valid)
  );

  // Masked lines track their input silently; the granted line latches its level.
  always_comb begin
    reported_d = (reported & irq_enable) | (interrupts & ~irq_enable);
    if (grant_take) begin
      reported_d = (reported_d & ~grant_mask) | (interrupts & grant_mask);
    end
  end

  // Output slot, reported levels and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      reported  <= '0;
      evt_valid <= 1'b0;
      evt_index <= '0;
      evt_level <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      reported <= reported_d;
      if (slot_free) begin
        evt_valid <= grant_valid;
        if (grant_valid) begin
          evt_index <= grant;
          evt_level <= grant_level;
          rr_ptr    <= IndexWidth'(next_rr_index(32'(grant), N));
        end
      end
    end
  end

`ifdef RENODE_INTERRUPTS_GLITCH_COUNT_EN
  logic [N-1:0] pend_q;
  logic [N-1:0] grant_q;
  logic         glitch;

  // A line left pending state without its grant on the previous edge.
  assign glitch = |(pend_q & ~pending & ~grant_q);

  // Saturating count of cycles with at least one dropped toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      grant_q    <= '0;
      glitch_cnt <= '0;
    end else begin
      pend_q  <= pending;
      grant_q <= grant_take ? grant_mask : '0;
      if (glitch && glitch_cnt != '1) begin
        glitch_cnt <= glitch_cnt + GlitchCntWidth'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_renode_interrupts_arbiter.sv
// Directed bench for renode_interrupts_arbiter with four lines.
module tb_renode_interrupts_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] interrupts;
  logic [3:0] irq_enable;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_index;
  logic       evt_level;
  logic [3:0] pending;
`ifdef RENODE_INTERRUPTS_GLITCH_COUNT_EN
  logic [15:0] glitch_cnt;
`endif

  int n_tests;
  int n_fail;

  renode_interrupts_arbiter #(
    .InterruptsCount (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .interrupts (interrupts),
    .irq_enable (irq_enable),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_index  (evt_index),
    .evt_level  (evt_level),
    .pending    (pending)
`ifdef RENODE_INTERRUPTS_GLITCH_COUNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_evt(input string tag, input logic v, input logic [1:0] idx, input logic lvl);
    check({tag, ".valid"}, 32'(evt_valid), 32'(v));
    if (v) begin
      check({tag, ".index"}, 32'(evt_index), 32'(idx));
      check({tag, ".level"}, 32'(evt_level), 32'(lvl));
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    interrupts = 4'b0000;
    irq_enable = 4'b1111;
    evt_ready  = 1'b1;
    tick();
    tick();
    check("rst.valid", 32'(evt_valid), 32'd0);
    check("rst.index", 32'(evt_index), 32'd0);
    check("rst.level", 32'(evt_level), 32'd0);
    check("rst.pending", 32'(pending), 32'd0);
`ifdef RENODE_INTERRUPTS_GLITCH_COUNT_EN
    check("rst.glitch", 32'(glitch_cnt), 32'd0);
`endif

    // Lines 0 and 2 high after reset
    interrupts = 4'b0101;
    rst        = 1'b0;
    #1;
    check("boot.pending", 32'(pending), 32'h5);
    tick(); check_evt("boot.e0", 1'b1, 2'd0, 1'b1);
    tick(); check_evt("boot.e1", 1'b1, 2'd2, 1'b1);
    tick(); check_evt("boot.idle", 1'b0, 2'd0, 1'b0);
    check("boot.pending_clr", 32'(pending), 32'h0);

    // Line 1 rise moves rr_ptr to 2
    interrupts = 4'b0111;
    tick(); check_evt("l1.e", 1'b1, 2'd1, 1'b1);
    tick(); check_evt("l1.idle", 1'b0, 2'd0, 1'b0);

    // Lines 0 and 3 together from rr_ptr=2: grant 3 then 0
    interrupts = 4'b1110;
    tick(); check_evt("rr.e3", 1'b1, 2'd3, 1'b1);
    tick(); check_evt("rr.e0", 1'b1, 2'd0, 1'b0);
    tick(); check_evt("rr.idle", 1'b0, 2'd0, 1'b0);

    // rr_ptr now 1: lines 0 and 2 together grant 2 first
    interrupts = 4'b1011;
    tick(); check_evt("rr1.e2", 1'b1, 2'd2, 1'b0);
    tick(); check_evt("rr1.e0", 1'b1, 2'd0, 1'b1);
    tick(); check_evt("rr1.idle", 1'b0, 2'd0, 1'b0);

    // Line 1 falls so it can rise for the stall test
    interrupts = 4'b1001;
    tick(); check_evt("pre.e1", 1'b1, 2'd1, 1'b0);
    tick(); check_evt("pre.idle", 1'b0, 2'd0, 1'b0);

    // Stall with (1,1) in the slot while line 2 rises
    evt_ready  = 1'b0;
    interrupts = 4'b1011;
    tick(); check_evt("stall.e1", 1'b1, 2'd1, 1'b1);
    interrupts = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_evt("stall.hold", 1'b1, 2'd1, 1'b1);
      check("stall.pending", 32'(pending), 32'h4);
    end
    evt_ready = 1'b1;
    tick(); check_evt("stall.e2", 1'b1, 2'd2, 1'b1);
    tick(); check_evt("stall.idle", 1'b0, 2'd0, 1'b0);

    // Line 3 pulses low and back during a stall: no event for it
    evt_ready  = 1'b0;
    interrupts = 4'b1110;
    tick(); check_evt("glitch.e0", 1'b1, 2'd0, 1'b0);
    interrupts = 4'b0110;
    tick(); check("glitch.pend3", 32'(pending), 32'h8);
    interrupts = 4'b1110;
    tick(); check("glitch.pend0", 32'(pending), 32'h0);
    check_evt("glitch.hold", 1'b1, 2'd0, 1'b0);
    evt_ready = 1'b1;
    tick(); check_evt("glitch.idle", 1'b0, 2'd0, 1'b0);
`ifdef RENODE_INTERRUPTS_GLITCH_COUNT_EN
    check("glitch.cnt", 32'(glitch_cnt), 32'd1);
`endif
    tick(); check_evt("glitch.idle2", 1'b0, 2'd0, 1'b0);

    // Masked line 1 toggles silently, enabling it emits nothing
    irq_enable = 4'b1101;
    interrupts = 4'b1100;
    tick(); check_evt("mask.t1", 1'b0, 2'd0, 1'b0);
    interrupts = 4'b1110;
    tick(); check_evt("mask.t2", 1'b0, 2'd0, 1'b0);
    check("mask.pending", 32'(pending), 32'h0);
    interrupts = 4'b1100;
    tick(); check_evt("mask.t3", 1'b0, 2'd0, 1'b0);
    irq_enable = 4'b1111;
    #1;
    check("mask.en_pending", 32'(pending), 32'h0);
    tick(); check_evt("mask.en", 1'b0, 2'd0, 1'b0);

    // Reset with an event in flight, then lines 1..3 re-report
    evt_ready  = 1'b0;
    interrupts = 4'b1110;
    tick(); check_evt("rr2.e1", 1'b1, 2'd1, 1'b1);
    rst = 1'b1;
    tick(); check_evt("rr2.rst", 1'b0, 2'd0, 1'b0);
    check("rr2.rst_index", 32'(evt_index), 32'd0);
`ifdef RENODE_INTERRUPTS_GLITCH_COUNT_EN
    check("rr2.glitch_clr", 32'(glitch_cnt), 32'd0);
`endif
    rst       = 1'b0;
    evt_ready = 1'b1;
    tick(); check_evt("rr2.e1b", 1'b1, 2'd1, 1'b1);
    tick(); check_evt("rr2.e2", 1'b1, 2'd2, 1'b1);
    tick(); check_evt("rr2.e3", 1'b1, 2'd3, 1'b1);
    tick(); check_evt("rr2.idle", 1'b0, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
